mem_bus_ctrl: RTL

Memory-side controller for the processor data bus. It accepts single-cycle read/write dispatch pulses with byte/halfword/word widths, drives `busy_out` for the whole transaction, and turns each request into one access on one of two targets: a byte-enabled data BRAM, or a request/acknowledge MMIO port. It sits directly downstream of the processor's MEM/WRITEBACK stages. Its `read_data_out` is right-justified, and the processor performs sign extension.

---
 rtl/mem.sv | 13 +
 rtl/mem_bus_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// Shared access-width encoding for the processor data bus.
//   BYTE  - 8-bit access
//   WORD  - 16-bit access
//   DWORD - 32-bit access
package mem;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      WORD  = 2'd1,
      DWORD = 2'd2
   } width_t;

endpackage : mem

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Memory-side controller for the processor data bus. Each single-cycle
// read/write dispatch becomes exactly one access to either the byte-enabled
// data BRAM (addresses below MMIO_BASE) or the req/ack MMIO port.
//
// Ports:
//   clk_in, rst_in           clock (rising edge), async active-low reset
//   dispatch_read_in/_write  one-cycle request pulses (write wins if both)
//   addr_in, mem_width_in    byte address and access width (mem::width_t)
//   write_data_in            right-justified store data
//   busy_out                 transaction in progress (combinational term)
//   read_data_out            right-justified, zero-filled load result
//   misalign_out             sticky misaligned-access flag
//   bram_*                   word address, byte enables, lane data, read data
//   mmio_*                   request/ack port with lane-positioned data
module mem_bus_ctrl #(
   parameter int          ADDR_W       = 14,
   parameter int          READ_LATENCY = 2,
   parameter logic [31:0] MMIO_BASE    = 32'h8000_0000
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              dispatch_read_in,
   input  logic              dispatch_write_in,
   input  logic [31:0]       addr_in,
   input  logic [1:0]        mem_width_in,
   input  logic [31:0]       write_data_in,
   output logic              busy_out,
   output logic [31:0]       read_data_out,
   output logic              misalign_out,
   output logic [ADDR_W-1:0] bram_addr_out,
   output logic [3:0]        bram_we_out,
   output logic [31:0]       bram_din_out,
   input  logic [31:0]       bram_dout_in,
   output logic              mmio_req_out,
   output logic              mmio_we_out,
   output logic [31:0]       mmio_addr_out,
   output logic [3:0]        mmio_be_out,
   output logic [31:0]       mmio_wdata_out,
   input  logic              mmio_ack_in,
   input  logic [31:0]       mmio_rdata_in
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RD_WAIT   = 3'd1;
   localparam logic [2:0] S_WR        = 3'd2;
   localparam logic [2:0] S_MMIO_WAIT = 3'd3;
   localparam logic [2:0] S_ERR       = 3'd4;

   // Width encoding 2'b11 is not defined; it is handled as a 32-bit access.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
      case (width)
         mem::BYTE: is_misaligned = 1'b0;
         mem::WORD: is_misaligned = off[0];
         default:   is_misaligned = (off != 2'b00);
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] off);
      case (width)
         mem::BYTE: lane_be = 4'b0001 << off;
         mem::WORD: lane_be = 4'b0011 << off;
         default:   lane_be = 4'b1111;
      endcase
   endfunction

   // Replicating the store data means every enabled lane already holds the
   // right bytes, whatever the offset.
   function automatic logic [31:0] lane_data(input logic [1:0] width, input logic [31:0] data);
      case (width)
         mem::BYTE: lane_data = {4{data[7:0]}};
         mem::WORD: lane_data = {2{data[15:0]}};
         default:   lane_data = data;
      endcase
   endfunction

   function automatic logic [31:0] align_rd(input logic [1:0] width, input logic [1:0] off,
                                            input logic [31:0] data);
      logic [31:0] shifted;
      shifted = data >> {off, 3'b000};
      case (width)
         mem::BYTE: align_rd = {24'h0, shifted[7:0]};
         mem::WORD: align_rd = {16'h0, shifted[15:0]};
         default:   align_rd = shifted;
      endcase
   endfunction

   logic [2:0]  r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_addr;
   logic [1:0]  r_width;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [31:0] r_rdata;
   logic        r_misalign;

   logic        w_dispatch;
   logic        w_misaligned;
   logic [3:0]  w_be;
   logic        w_mmio_req;

   assign w_dispatch   = dispatch_read_in | dispatch_write_in;
   assign w_misaligned = is_misaligned(mem_width_in, addr_in[1:0]);
   assign w_be         = lane_be(r_width, r_addr[1:0]);
   assign w_mmio_req   = (r_state == S_MMIO_WAIT);

   // busy includes the raw dispatch so the processor stalls on the edge right
   // after it dispatches; gated by reset so every output reads 0 in reset.
   assign busy_out = rst_in & ((r_state != S_IDLE) | w_dispatch);

   assign read_data_out  = r_rdata;
   assign misalign_out   = r_misalign;
   assign bram_addr_out  = r_addr[ADDR_W+1:2];
   assign bram_we_out    = (r_state == S_WR) ? w_be : 4'b0000;
   assign bram_din_out   = lane_data(r_width, r_wdata);
   assign mmio_req_out   = w_mmio_req;
   assign mmio_we_out    = w_mmio_req & r_we;
   assign mmio_addr_out  = r_addr;
   assign mmio_be_out    = w_mmio_req ? w_be : 4'b0000;
   assign mmio_wdata_out = lane_data(r_width, r_wdata);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_addr     <= 32'h0;
         r_width    <= 2'b00;
         r_wdata    <= 32'h0;
         r_we       <= 1'b0;
         r_rdata    <= 32'h0;
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_dispatch) begin
                  r_addr  <= addr_in;
                  r_width <= mem_width_in;
                  r_wdata <= write_data_in;
                  r_we    <= dispatch_write_in;
                  if (w_misaligned) begin
                     r_state    <= S_ERR;
                     r_misalign <= 1'b1;
                     // Only a misaligned read clobbers the load result.
                     if (!dispatch_write_in) begin
                        r_rdata <= 32'h0;
                     end
                  end else if (addr_in >= MMIO_BASE) begin
                     r_state <= S_MMIO_WAIT;
                  end else if (dispatch_write_in) begin
                     r_state <= S_WR;
                  end else begin
                     r_state <= S_RD_WAIT;
                     r_cnt   <= 3'(READ_LATENCY);
                  end
               end
            end
            S_RD_WAIT: begin
               if (r_cnt == 3'd0) begin
                  r_rdata <= align_rd(r_width, r_addr[1:0], bram_dout_in);
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_MMIO_WAIT: begin
               if (mmio_ack_in) begin
                  if (!r_we) begin
                     r_rdata <= align_rd(r_width, r_addr[1:0], mmio_rdata_in);
                  end
                  r_state <= S_IDLE;
               end
            end
            S_WR:    r_state <= S_IDLE;
            S_ERR:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule : mem_bus_ctrl
